// File: rtl/up_down_count_monitor.sv
// Passive monitor for an up/down counter bus: infers and locks the counting
// direction, then pulses on holds, reversals and illegal jumps.
module up_down_count_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     count_in,
  output logic                 locked,
  output logic                 dir,
  output logic                 held,
  output logic                 reversal,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     last_value,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t               state_q, state_d;
  logic [3:0]           run_q, run_d;
  logic                 cand_q, cand_d;
  logic                 locked_d, dir_d, held_d, reversal_d, step_err_d;
  logic [ERR_CNT_W-1:0] err_count_d;
  logic [WIDTH-1:0]     last_value_d;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_hold;
  logic             step_dir;
  logic [3:0]       run_next;

  assign delta    = count_in - last_value;
  assign is_up    = (delta == ONE);
  assign is_dn    = (delta == '1);
  assign is_hold  = (delta == '0);
  assign step_dir = is_up;

  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_q      <= '0;
      cand_q     <= 1'b0;
      locked     <= 1'b0;
      dir        <= 1'b0;
      held       <= 1'b0;
      reversal   <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
      last_value <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      cand_q     <= cand_d;
      locked     <= locked_d;
      dir        <= dir_d;
      held       <= held_d;
      reversal   <= reversal_d;
      step_err   <= step_err_d;
      err_count  <= err_count_d;
      last_value <= last_value_d;
    end
  end

  // enable is a plain sample strobe: count_in is consumed on every edge where
  // enable=1 and ignored otherwise; there is no back-pressure. clr beats enable.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    cand_d       = cand_q;
    locked_d     = locked;
    dir_d        = dir;
    held_d       = 1'b0;
    reversal_d   = 1'b0;
    step_err_d   = 1'b0;
    err_count_d  = err_count;
    last_value_d = last_value;
    run_next     = run_q + 4'd1;

    if (clr) begin
      state_d      = IDLE;
      run_d        = '0;
      cand_d       = 1'b0;
      locked_d     = 1'b0;
      dir_d        = 1'b0;
      err_count_d  = '0;
      last_value_d = '0;
    end else if (enable) begin
      last_value_d = count_in;
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          run_d   = '0;
        end
        ACQUIRE: begin
          if (is_up || is_dn) begin
            if (run_q != 4'd0 && step_dir != cand_q) run_next = 4'd1;
            run_d  = run_next;
            cand_d = step_dir;
            if (run_next == LOCK_RUN) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              dir_d    = step_dir;
            end
          end else if (!is_hold) begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (is_hold) begin
            held_d = 1'b1;
          end else if (is_up || is_dn) begin
            if (step_dir != dir) begin
              reversal_d = 1'b1;
              run_d      = 4'd1;
              cand_d     = step_dir;
              // A lock length of one relocks on the reversing step itself.
              if (LOCK_RUN == 4'd1) begin
                dir_d = step_dir;
              end else begin
                state_d  = ACQUIRE;
                locked_d = 1'b0;
              end
            end
          end else begin
            step_err_d = 1'b1;
            if (err_count != '1) err_count_d = err_count + 1'b1;
            state_d  = ACQUIRE;
            run_d    = '0;
            locked_d = 1'b0;
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Directed bench for up_down_count_monitor (WIDTH=4, LOCK_COUNT=3, ERR_CNT_W=2)
// with hand-computed expectations after each sampled edge.
module tb_up_down_count_monitor;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       clr;
  logic [3:0] count_in;
  logic       locked, dir, held, reversal, step_err;
  logic [1:0] err_count;
  logic [3:0] last_value;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  up_down_count_monitor #(
    .WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr),
    .count_in(count_in), .locked(locked), .dir(dir), .held(held),
    .reversal(reversal), .step_err(step_err), .err_count(err_count),
    .last_value(last_value), .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic drive(input logic en, input logic cl, input logic [3:0] v);
    @(negedge clk);
    enable   = en;
    clr      = cl;
    count_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [3:0] v);
    drive(1'b1, 1'b0, v);
  endtask

  task automatic expect_out(input string tag, input int lk, input int dr,
                            input int h, input int r, input int se, input int ec);
    check({tag, ".locked"}, int'(locked), lk);
    if (lk == 1) check({tag, ".dir"}, int'(dir), dr);
    check({tag, ".held"}, int'(held), h);
    check({tag, ".reversal"}, int'(reversal), r);
    check({tag, ".step_err"}, int'(step_err), se);
    check({tag, ".err_count"}, int'(err_count), ec);
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    clr      = 1'b0;
    count_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    check("reset.dir", int'(dir), 0);
    check("reset.last_value", int'(last_value), 0);
    check("reset.state", int'(fsm_state), 0);
    @(negedge clk);
    reset = 1'b1;

    // Up lock from IDLE: four samples, locked after the one carrying 3.
    samp(4'd0);
    check("cap.state", int'(fsm_state), 1);
    check("cap.last_value", int'(last_value), 0);
    samp(4'd1); expect_out("up1", 0, 0, 0, 0, 0, 0);
    samp(4'd2); expect_out("up2", 0, 0, 0, 0, 0, 0);
    samp(4'd3); expect_out("up3", 1, 1, 0, 0, 0, 0);
    check("up3.state", int'(fsm_state), 2);

    // Up wrap 15 -> 0 is a legal unit step.
    drive(1'b1, 1'b1, 4'd0);
    samp(4'd12); samp(4'd13); samp(4'd14);
    expect_out("wrapu.pre", 0, 0, 0, 0, 0, 0);
    samp(4'd15); expect_out("wrapu.lock", 1, 1, 0, 0, 0, 0);
    samp(4'd0);  expect_out("wrapu.0", 1, 1, 0, 0, 0, 0);
    samp(4'd1);  expect_out("wrapu.1", 1, 1, 0, 0, 0, 0);

    // Down wrap 0 -> 15.
    drive(1'b1, 1'b1, 4'd0);
    samp(4'd3); samp(4'd2); samp(4'd1);
    samp(4'd0);  expect_out("wrapd.lock", 1, 0, 0, 0, 0, 0);
    samp(4'd15); expect_out("wrapd.15", 1, 0, 0, 0, 0, 0);
    samp(4'd14); expect_out("wrapd.14", 1, 0, 0, 0, 0, 0);

    // Hold, reversal, relock down.
    drive(1'b1, 1'b1, 4'd0);
    samp(4'd2); samp(4'd3); samp(4'd4);
    samp(4'd5); expect_out("rev.lock", 1, 1, 0, 0, 0, 0);
    samp(4'd6); expect_out("rev.6", 1, 1, 0, 0, 0, 0);
    samp(4'd6); expect_out("rev.hold", 1, 1, 1, 0, 0, 0);
    samp(4'd5); expect_out("rev.rev", 0, 0, 0, 1, 0, 0);
    samp(4'd4); expect_out("rev.4", 0, 0, 0, 0, 0, 0);
    samp(4'd3); expect_out("rev.relock", 1, 0, 0, 0, 0, 0);

    // Jumps with a 2-bit saturating tally.
    drive(1'b1, 1'b1, 4'd0);
    samp(4'd2); samp(4'd3); samp(4'd4); samp(4'd5);
    samp(4'd9);  expect_out("jmp1", 0, 0, 0, 0, 1, 1);
    samp(4'd10); expect_out("jmp1.after", 0, 0, 0, 0, 0, 1);
    samp(4'd11); samp(4'd12); expect_out("jmp1.relock", 1, 1, 0, 0, 0, 1);
    samp(4'd0);  expect_out("jmp2", 0, 0, 0, 0, 1, 2);
    samp(4'd1); samp(4'd2); samp(4'd3);
    samp(4'd9);  expect_out("jmp3", 0, 0, 0, 0, 1, 3);
    samp(4'd10); samp(4'd11); samp(4'd12);
    samp(4'd5);  expect_out("jmp4.sat", 0, 0, 0, 0, 1, 3);
    samp(4'd5);  expect_out("jmp4.hold_unlocked", 0, 0, 0, 0, 0, 3);
    samp(4'd12); expect_out("jmp.unlocked_noerr", 0, 0, 0, 0, 0, 3);

    // Strobe low freezes everything.
    samp(4'd13); samp(4'd14);
    samp(4'd15); expect_out("strobe.lock", 1, 1, 0, 0, 0, 3);
    drive(1'b0, 1'b0, 4'd3);
    drive(1'b0, 1'b0, 4'd9);
    drive(1'b0, 1'b0, 4'd15);
    expect_out("strobe.frozen", 1, 1, 0, 0, 0, 3);
    check("strobe.last_value", int'(last_value), 15);
    samp(4'd0); expect_out("strobe.resume", 1, 1, 0, 0, 0, 3);

    // clr has priority over enable.
    drive(1'b1, 1'b1, 4'd7);
    expect_out("clr", 0, 0, 0, 0, 0, 0);
    check("clr.state", int'(fsm_state), 0);
    check("clr.last_value", int'(last_value), 0);
    samp(4'd7);
    check("clr.cap_state", int'(fsm_state), 1);
    check("clr.cap_last", int'(last_value), 7);

    // Asynchronous reset between edges while locked.
    samp(4'd8); samp(4'd9);
    samp(4'd10); expect_out("arst.lock", 1, 1, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    expect_out("arst.now", 0, 0, 0, 0, 0, 0);
    check("arst.dir", int'(dir), 0);
    check("arst.last_value", int'(last_value), 0);
    check("arst.state", int'(fsm_state), 0);
    @(negedge clk);
    reset = 1'b1;
    samp(4'd8);
    check("arst.cap_state", int'(fsm_state), 1);
    samp(4'd9); samp(4'd10);
    expect_out("arst.10", 0, 0, 0, 0, 0, 0);
    samp(4'd11); expect_out("arst.relock", 1, 1, 0, 0, 0, 0);
    check("arst.relock_last", int'(last_value), 11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/up_down_count_monitor.md
# up_down_count_monitor

Passive checker that sits on the output bus of an up/down counter and decodes its behaviour from the value stream alone. It infers the counting direction and locks onto it after a run of consistent steps. It flags holds, direction reversals and illegal jumps, and keeps a saturating error tally. It is the reader-side companion to the counter and is used in integration benches and as an on-chip health monitor.

## Interface
- WIDTH, 4: width of the observed count.
- LOCK_COUNT, 3: consecutive same-direction unit steps required to lock (range 1 to 15).
- ERR_CNT_W, 8: width of the error tally.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- enable  input  1  sample strobe; count_in is evaluated only on edges where enable=1.
- clr  input  1  synchronous clear to the reset state; has priority over enable.
- count_in  input  WIDTH  counter value under observation.
- locked  output  1  direction lock established.
- dir  output  1  locked direction: 1 = up, 0 = down; valid only when locked=1.
- held  output  1  one-cycle pulse: value unchanged while locked.
- reversal  output  1  one-cycle pulse: opposite unit step while locked.
- step_err  output  1  one-cycle pulse: illegal jump while locked.
- err_count  output  ERR_CNT_W  saturating count of step_err events.
- last_value  output  WIDTH  most recently sampled count_in.

## Operation
- Step classification uses d = count_in − last_value mod 2^WIDTH:
  - d = 1 is UP. This includes the wrap from all-ones to 0.
  - d = all-ones is DOWN. This includes the wrap from 0 to all-ones.
  - d = 0 is HOLD.
  - Any other d is JUMP.
- State machine states: IDLE, ACQUIRE, LOCKED. The internal run counter is 4 bits; cand is the candidate direction.
- IDLE: on enable, last_value ← count_in and the block moves to ACQUIRE with run=0. No step is classified.
- ACQUIRE, per enabled sample:
  - UP or DOWN when run=0 or the step matches cand: run++ and cand ← step direction.
  - UP or DOWN opposite to cand with run>0: run=1 and cand ← step direction.
  - When run reaches LOCK_COUNT: move to LOCKED, locked=1, dir=cand.
  - HOLD: no change.
  - JUMP: run=0. No error is raised while unlocked.
- LOCKED, per enabled sample:
  - Step matching dir: stay in LOCKED, no pulse.
  - HOLD: pulse held and stay in LOCKED.
  - Opposite unit step: pulse reversal, locked=0, move to ACQUIRE with run=1 and cand set to the new direction. If LOCK_COUNT=1, go straight back to LOCKED with the new dir.
  - JUMP: pulse step_err, increment err_count (saturating at all-ones), locked=0, move to ACQUIRE with run=0.
- last_value updates on every enabled sample outside of clr.
- clr=1 returns the block to IDLE and sets every output to its reset value, including err_count.
- Only one of held, reversal or step_err can be high in any cycle.

## Timing
- Reset values: state IDLE, run 0, locked 0, dir 0, held 0, reversal 0, step_err 0, err_count 0, last_value 0.
- Reset acts immediately on assertion, including mid-lock. The first enabled edge after release is treated as an IDLE capture.
- All outputs are registered. Results appear the cycle after the rising edge that sampled count_in with enable=1.
- Pulses are high for exactly one clock. With enable=0 the state is frozen and all pulses are 0.
- locked asserts on the edge that samples the LOCK_COUNT-th consistent step. From IDLE this is LOCK_COUNT+1 enabled samples.
- Latency from a violating sample to its pulse: 1 edge.

## Test plan
- Up lock: reset, then enable each cycle with 0,1,2,3. locked=1 and dir=1 after the edge that samples 3. No pulses.
- Wrap: locked up on 13,14,15, then 0,1. Response: no pulse, err_count=0, locked stays 1. Repeat down through 0→15. Response: dir=0, no error.
- Reversal and hold: locked up at 5, then 6,6,5,4,3. Responses:
  - held pulses once.
  - reversal pulses on the sample of 5.
  - locked drops, then reasserts with dir=0 at the sample of 3.
- Jump and saturation: with ERR_CNT_W=2, lock, then inject 4 jumps (e.g. 5→9), relocking between them. step_err pulses 4 times and err_count ends at 3.
- Strobe and clear: while locked, hold enable=0 with arbitrary count_in. Response: no change. Then pulse clr with enable=1. Response: IDLE state, err_count=0, last_value=0.
- Async reset mid-lock: drop reset between clock edges. Response: all outputs 0 immediately. After release, relock on 8,9,10,11.
